sat_mul_arbiter: RTL and testbench

- Shares one signed multiply, fixed-point shift and saturate datapath between NREQ requesters. Typical requesters are the V-loop and I-loop PI gain stages and the feed-forward scaling.
- Round-robin arbitration on the request side; two-stage pipeline; single valid/ready response port tagged with the requester id.
- Results are clipped to OUT_W signed range. A saturation flag and a saturation-event counter are provided for loop diagnostics.

---
 rtl/sat_mul_arbiter.sv | 155 +++++++++++++++
 tb/tb_sat_mul_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_mul_arbiter.sv
// Round-robin shared signed multiply / arithmetic-shift / saturate datapath.
// Two pipeline stages with a single valid/ready response port tagged by requester id.
module sat_mul_arbiter #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 16,
    parameter int OUT_W = 16,
    parameter int FRAC  = 14,
    parameter int ID_W  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*IN_W-1:0]   req_a,
    input  logic [NREQ*IN_W-1:0]   req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [OUT_W-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_sat,
    output logic [15:0]            sat_cnt,
    input  logic                   sat_cnt_clr
);

    localparam int PW = 2 * IN_W;
    localparam logic signed [PW-1:0] MAX_V = {{(PW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_V = ~MAX_V;

    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]        s1_id_q, s1_id_d;
    logic signed [PW-1:0]   s1_prod_q, s1_prod_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [OUT_W-1:0]       rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]        rsp_id_q, rsp_id_d;
    logic                   rsp_sat_q, rsp_sat_d;
    logic [15:0]            sat_cnt_q, sat_cnt_d;

    logic                   s1_en, s2_en, accept, gnt_found;
    logic [ID_W-1:0]        gnt_idx, cand;
    logic signed [IN_W-1:0] a_sel, b_sel;
    logic signed [PW-1:0]   shifted;

    assign s2_en = !rsp_valid_q || rsp_ready;
    assign s1_en = !s1_valid_q || s2_en;

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % NREQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (ID_W'(k) == gnt_idx) begin
                a_sel = req_a[k*IN_W +: IN_W];
                b_sel = req_b[k*IN_W +: IN_W];
            end
        end
    end

    assign accept    = s1_en && gnt_found;
    assign req_ready = accept ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        ptr_d      = ptr_q;
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        s1_prod_d  = s1_prod_q;
        if (s1_en) begin
            s1_valid_d = accept;
        end
        if (accept) begin
            s1_id_d   = gnt_idx;
            s1_prod_d = PW'(a_sel) * PW'(b_sel);
            ptr_d     = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    assign shifted = s1_prod_q >>> FRAC;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_sat_d   = rsp_sat_q;
        if (s2_en) begin
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_id_d = s1_id_q;
                if (shifted > MAX_V) begin
                    rsp_data_d = MAX_V[OUT_W-1:0];
                    rsp_sat_d  = 1'b1;
                end else if (shifted < MIN_V) begin
                    rsp_data_d = MIN_V[OUT_W-1:0];
                    rsp_sat_d  = 1'b1;
                end else begin
                    rsp_data_d = shifted[OUT_W-1:0];
                    rsp_sat_d  = 1'b0;
                end
            end
        end
    end

    // Clear beats a same-cycle saturating transfer; counter sticks at all-ones.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_cnt_clr) begin
            sat_cnt_d = '0;
        end else if (rsp_valid_q && rsp_ready && rsp_sat_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_prod_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_sat_q   <= 1'b0;
            sat_cnt_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_prod_q   <= s1_prod_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sat_q   <= rsp_sat_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sat   = rsp_sat_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_sat_mul_arbiter.sv
// Scoreboard bench for sat_mul_arbiter: directed stimulus pushes hand-computed
// responses; an independent monitor pops and compares on every transfer.
module tb_sat_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_sat;
    logic [15:0] sat_cnt;
    logic        sat_cnt_clr = 1'b0;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  id;
        logic        sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_xfer = 0;

    sat_mul_arbiter #(.NREQ(4), .IN_W(16), .OUT_W(16), .FRAC(14)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_sat(rsp_sat),
        .sat_cnt(sat_cnt), .sat_cnt_clr(sat_cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input int id, input int data, input logic sat);
        exp_t e;
        e.data = 16'(data);
        e.id   = 2'(id);
        e.sat  = sat;
        exp_q.push_back(e);
    endtask

    // Transfer is decided on the sampled values; it completes at the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && rsp_valid && rsp_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_data), 32'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_id",   32'(rsp_id),   32'(e.id));
                    chk("rsp_sat",  32'(rsp_sat),  32'(e.sat));
                end
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        req_a[i*16 +: 16] = 16'(a);
        req_b[i*16 +: 16] = 16'(b);
    endtask

    task automatic send(input int i, input int a, input int b);
        int t;
        @(negedge clk);
        set_ops(i, a, b);
        req_valid[i] = 1'b1;
        #1;
        t = 0;
        while (!req_ready[i] && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 20) chk("send_timeout", 32'(t), 32'd0);
        @(negedge clk);
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (t >= 30) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        #2;
    endtask

    task automatic run_mask(input logic [3:0] mask, input int n);
        int acc;
        acc = 0;
        @(negedge clk);
        req_valid = mask;
        for (int t = 0; t < 50 && acc < n; t++) begin
            #1;
            if (|(req_ready & req_valid)) acc++;
            @(negedge clk);
        end
        req_valid = '0;
        if (acc != n) chk("accept_count", 32'(acc), 32'(n));
    endtask

    initial begin
        int base;
        int t;

        #3 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_sat_cnt",   32'(sat_cnt),   32'd0);
        reset_dut();

        // Single transfer and latency.
        push(0, 8192, 1'b0);
        @(negedge clk);
        set_ops(0, 16384, 8192);
        req_valid[0] = 1'b1;
        #1 chk("first_req_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1 chk("lat_valid_T", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1 chk("lat_valid_T1", 32'(rsp_valid), 32'd1);
        drain();

        // Saturation at both rails.
        push(0, 32767, 1'b1);
        send(0, -32768, -32768);
        push(0, -32768, 1'b1);
        send(0, 32767, -32768);
        drain();
        chk("sat_cnt_2", 32'(sat_cnt), 32'd2);

        // Floor shift, no rounding.
        push(0, -1, 1'b0);
        send(0, -1, 1);
        push(0, 0, 1'b0);
        send(0, 1, 1);
        push(0, -16384, 1'b0);
        send(0, -16384, 16384);
        drain();
        chk("sat_cnt_still_2", 32'(sat_cnt), 32'd2);

        // Round robin over all four, then over requesters 1 and 3.
        for (int i = 0; i < 4; i++) set_ops(i, (i + 1) * 1024, 16384);
        reset_dut();
        push(0, 1024, 1'b0); push(1, 2048, 1'b0); push(2, 3072, 1'b0);
        push(3, 4096, 1'b0); push(0, 1024, 1'b0); push(1, 2048, 1'b0);
        run_mask(4'b1111, 6);
        drain();
        reset_dut();
        push(1, 2048, 1'b0); push(3, 4096, 1'b0);
        push(1, 2048, 1'b0); push(3, 4096, 1'b0);
        run_mask(4'b1010, 4);
        drain();

        // Backpressure: two accepts, frozen output, then gap-free in-order release.
        reset_dut();
        push(0, 1024, 1'b0); push(1, 2048, 1'b0);
        push(2, 3072, 1'b0); push(3, 4096, 1'b0);
        begin
            int acc;
            acc = 0;
            base = n_xfer;
            @(negedge clk);
            req_valid = 4'b1111;
            for (int cyc = 0; cyc < 40 && acc < 4; cyc++) begin
                rsp_ready = (cyc >= 7);
                #1;
                if (cyc >= 2 && cyc <= 6) begin
                    chk("bp_req_ready", 32'(req_ready), 32'd0);
                    chk("bp_data_hold", 32'(rsp_data), 32'd1024);
                end
                if (cyc == 6) base = n_xfer;
                if (|(req_ready & req_valid)) acc++;
                @(negedge clk);
            end
            req_valid = '0;
            @(negedge clk);
            @(negedge clk);
            #2 chk("bp_no_gap", 32'(n_xfer - base), 32'd4);
        end
        drain();

        // Counter sticks at all-ones.
        @(negedge clk);
        force dut.sat_cnt_d = 16'hFFFE;
        @(negedge clk);
        release dut.sat_cnt_d;
        #1 chk("sat_cnt_preset", 32'(sat_cnt), 32'hFFFE);
        push(0, 32767, 1'b1);
        send(0, -32768, -32768);
        push(0, 32767, 1'b1);
        send(0, -32768, -32768);
        drain();
        chk("sat_cnt_sticky", 32'(sat_cnt), 32'hFFFF);

        // Async reset mid-stream with two items in flight.
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 4'b1111;
        repeat (3) @(negedge clk);
        #1 chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_data",  32'(rsp_data),  32'd0);
        chk("mid_rst_id",    32'(rsp_id),    32'd0);
        chk("mid_rst_sat",   32'(rsp_sat),   32'd0);
        chk("mid_rst_cnt",   32'(sat_cnt),   32'd0);
        chk("mid_rst_ptr",   32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        exp_q.delete();

        // Clear wins over a same-cycle saturating transfer.
        push(0, 32767, 1'b1);
        send(0, -32768, -32768);
        drain();
        chk("sat_cnt_1", 32'(sat_cnt), 32'd1);
        rsp_ready = 1'b0;
        push(0, -32768, 1'b1);
        send(0, 32767, -32768);
        t = 0;
        #1;
        while (!rsp_valid && t < 10) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 10) chk("clr_wait_timeout", 32'(t), 32'd0);
        @(negedge clk);
        sat_cnt_clr = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        sat_cnt_clr = 1'b0;
        #2 chk("sat_cnt_clr_prio", 32'(sat_cnt), 32'd0);
        drain();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
